// File: rtl/axi_eoc_mailbox.sv
// AXI4 slave register file whose word 0 is a tohost end-of-computation mailbox
// and word 1 drives a level interrupt; one transaction is serviced at a time.
module axi_eoc_mailbox #(
    parameter int unsigned          AddrWidth = 64,
    parameter int unsigned          DataWidth = 64,
    parameter int unsigned          IdWidth   = 8,
    parameter int unsigned          NumWords  = 8,
    parameter logic [AddrWidth-1:0] BaseAddr  = '0,
    parameter type axi_req_t = struct packed {
        logic [IdWidth-1:0]       aw_id;
        logic [AddrWidth-1:0]     aw_addr;
        logic [7:0]               aw_len;
        logic [2:0]               aw_size;
        logic [1:0]               aw_burst;
        logic                     aw_valid;
        logic [DataWidth-1:0]     w_data;
        logic [DataWidth/8-1:0]   w_strb;
        logic                     w_last;
        logic                     w_valid;
        logic                     b_ready;
        logic [IdWidth-1:0]       ar_id;
        logic [AddrWidth-1:0]     ar_addr;
        logic [7:0]               ar_len;
        logic [2:0]               ar_size;
        logic [1:0]               ar_burst;
        logic                     ar_valid;
        logic                     r_ready;
    },
    parameter type axi_resp_t = struct packed {
        logic                     aw_ready;
        logic                     ar_ready;
        logic                     w_ready;
        logic                     b_valid;
        logic [IdWidth-1:0]       b_id;
        logic [1:0]               b_resp;
        logic                     r_valid;
        logic [IdWidth-1:0]       r_id;
        logic [DataWidth-1:0]     r_data;
        logic [1:0]               r_resp;
        logic                     r_last;
    }
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  axi_req_t    axi_req_i,
    output axi_resp_t   axi_rsp_o,
    output logic        eoc_o,
    output logic [31:0] exit_code_o,
    output logic        irq_o
);
    localparam int unsigned StrbW = DataWidth / 8;
    localparam int unsigned IdxW  = $clog2(NumWords);

    typedef enum logic [1:0] {S_IDLE, S_WDATA, S_WRESP, S_RDATA} state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [IdWidth-1:0]     r_id;
    logic [AddrWidth-1:0]   r_addr;
    logic [7:0]             r_len;
    logic [7:0]             r_cnt;
    logic [1:0]             r_burst;
    logic                   r_err;
    logic                   r_last_wr;
    logic [DataWidth-1:0]   r_regs [NumWords];
    logic                   r_eoc;
    logic [31:0]            r_exit;

    logic                   w_grant_wr;
    logic                   w_grant_rd;
    logic                   w_w_hs;
    logic                   w_r_hs;
    logic                   w_r_last;
    logic [AddrWidth-1:0]   w_off;
    logic                   w_oob;
    logic [IdxW-1:0]        w_idx;
    logic [AddrWidth-1:0]   w_adv_addr;
    logic [DataWidth-1:0]   w_merged;
    logic [DataWidth-1:0]   w_rdata;
    logic                   w_unused;

    // On a simultaneous request the channel not granted last wins.
    assign w_grant_wr = (r_state == S_IDLE) && !rst_i && axi_req_i.aw_valid
                        && (!axi_req_i.ar_valid || !r_last_wr);
    assign w_grant_rd = (r_state == S_IDLE) && !rst_i && axi_req_i.ar_valid && !w_grant_wr;
    assign w_w_hs     = (r_state == S_WDATA) && axi_req_i.w_valid;
    assign w_r_hs     = (r_state == S_RDATA) && axi_req_i.r_ready;
    assign w_r_last   = (r_cnt == r_len);

    assign w_off      = r_addr - BaseAddr;
    assign w_oob      = (r_addr < BaseAddr) || (w_off[AddrWidth-1:3+IdxW] != '0);
    assign w_idx      = w_off[3 +: IdxW];
    assign w_adv_addr = (r_burst == 2'b00) ? r_addr : r_addr + AddrWidth'(8);
    assign w_rdata    = w_oob ? '0 : r_regs[w_idx];

    // IRQ keeps only bit 0 so the other bits read back as zero.
    always_comb begin
        w_merged = r_regs[w_idx];
        for (int b = 0; b < StrbW; b++) begin
            if (axi_req_i.w_strb[b]) w_merged[8*b +: 8] = axi_req_i.w_data[8*b +: 8];
        end
        if (w_idx == IdxW'(1)) w_merged = {{(DataWidth-1){1'b0}}, w_merged[0]};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next             = r_state;
        axi_rsp_o          = '0;
        axi_rsp_o.aw_ready = w_grant_wr;
        axi_rsp_o.ar_ready = w_grant_rd;
        case (r_state)
            S_IDLE: begin
                if (w_grant_wr)      w_next = S_WDATA;
                else if (w_grant_rd) w_next = S_RDATA;
            end
            S_WDATA: begin
                axi_rsp_o.w_ready = 1'b1;
                if (w_w_hs && axi_req_i.w_last) w_next = S_WRESP;
            end
            S_WRESP: begin
                axi_rsp_o.b_valid = 1'b1;
                axi_rsp_o.b_id    = r_id;
                axi_rsp_o.b_resp  = r_err ? 2'b10 : 2'b00;
                if (axi_req_i.b_ready) w_next = S_IDLE;
            end
            S_RDATA: begin
                axi_rsp_o.r_valid = 1'b1;
                axi_rsp_o.r_id    = r_id;
                axi_rsp_o.r_data  = w_rdata;
                axi_rsp_o.r_resp  = w_oob ? 2'b10 : 2'b00;
                axi_rsp_o.r_last  = w_r_last;
                if (w_r_hs && w_r_last) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_id      <= '0;
            r_addr    <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_burst   <= '0;
            r_err     <= 1'b0;
            r_last_wr <= 1'b0;
            r_eoc     <= 1'b0;
            r_exit    <= '0;
            for (int i = 0; i < NumWords; i++) r_regs[i] <= '0;
        end else begin
            if (w_grant_wr) begin
                r_id      <= axi_req_i.aw_id;
                r_addr    <= axi_req_i.aw_addr;
                r_len     <= axi_req_i.aw_len;
                r_burst   <= axi_req_i.aw_burst;
                r_cnt     <= '0;
                r_err     <= 1'b0;
                r_last_wr <= 1'b1;
            end else if (w_grant_rd) begin
                r_id      <= axi_req_i.ar_id;
                r_addr    <= axi_req_i.ar_addr;
                r_len     <= axi_req_i.ar_len;
                r_burst   <= axi_req_i.ar_burst;
                r_cnt     <= '0;
                r_err     <= 1'b0;
                r_last_wr <= 1'b0;
            end
            // Only the first tohost write with bit 0 set freezes the exit code.
            if (w_w_hs) begin
                if (!w_oob) begin
                    r_regs[w_idx] <= w_merged;
                    if (w_idx == '0 && !r_eoc && w_merged[0]) begin
                        r_eoc  <= 1'b1;
                        r_exit <= {1'b0, w_merged[31:1]};
                    end
                end
                r_err <= r_err | w_oob | (axi_req_i.w_last && (r_cnt != r_len));
                if (!axi_req_i.w_last) begin
                    r_cnt  <= r_cnt + 8'd1;
                    r_addr <= w_adv_addr;
                end
            end
            if (w_r_hs && !w_r_last) begin
                r_cnt  <= r_cnt + 8'd1;
                r_addr <= w_adv_addr;
            end
        end
    end

    assign eoc_o       = r_eoc;
    assign exit_code_o = r_exit;
    assign irq_o       = r_regs[1][0];
    assign w_unused    = ^{axi_req_i.aw_size, axi_req_i.ar_size, w_off[2:0]};

endmodule

// File: tb/tb_axi_eoc_mailbox.sv
// Randomised and directed bench for axi_eoc_mailbox against a word-array model
// of the register file, tohost mailbox and interrupt bit.
module tb_axi_eoc_mailbox;
    localparam logic [63:0] BASE = 64'h1000;
    localparam int          NW   = 8;

    typedef struct packed {
        logic [7:0]  aw_id;
        logic [63:0] aw_addr;
        logic [7:0]  aw_len;
        logic [2:0]  aw_size;
        logic [1:0]  aw_burst;
        logic        aw_valid;
        logic [63:0] w_data;
        logic [7:0]  w_strb;
        logic        w_last;
        logic        w_valid;
        logic        b_ready;
        logic [7:0]  ar_id;
        logic [63:0] ar_addr;
        logic [7:0]  ar_len;
        logic [2:0]  ar_size;
        logic [1:0]  ar_burst;
        logic        ar_valid;
        logic        r_ready;
    } req_t;

    typedef struct packed {
        logic        aw_ready;
        logic        ar_ready;
        logic        w_ready;
        logic        b_valid;
        logic [7:0]  b_id;
        logic [1:0]  b_resp;
        logic        r_valid;
        logic [7:0]  r_id;
        logic [63:0] r_data;
        logic [1:0]  r_resp;
        logic        r_last;
    } resp_t;

    logic        clk;
    logic        rst_i;
    req_t        req;
    resp_t       rsp;
    logic        eoc_o;
    logic [31:0] exit_code_o;
    logic        irq_o;

    axi_eoc_mailbox #(
        .AddrWidth(64), .DataWidth(64), .IdWidth(8), .NumWords(NW), .BaseAddr(BASE),
        .axi_req_t(req_t), .axi_resp_t(resp_t)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .axi_req_i(req), .axi_rsp_o(rsp),
        .eoc_o(eoc_o), .exit_code_o(exit_code_o), .irq_o(irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    bit          cmp_en = 1'b0;
    logic [63:0] mem [NW];
    bit          m_eoc;
    logic [31:0] m_exit;
    logic [63:0] wd [256];
    logic [7:0]  ws [256];
    logic [63:0] g_rdata [256];
    logic [1:0]  g_rresp [256];
    logic [1:0]  g_bresp;
    logic        g_other;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit m_oob(input logic [63:0] a);
        return (a < BASE) || (((a - BASE) >> 3) >= 64'(NW));
    endfunction

    function automatic int m_idx(input logic [63:0] a);
        return int'((a - BASE) >> 3);
    endfunction

    function automatic logic [63:0] m_read(input logic [63:0] a);
        return m_oob(a) ? 64'd0 : mem[m_idx(a)];
    endfunction

    task automatic m_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
        logic [63:0] v;
        int          i;
        if (m_oob(a)) return;
        i = m_idx(a);
        v = mem[i];
        for (int b = 0; b < 8; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
        if (i == 1) v = v & 64'd1;
        mem[i] = v;
        if (i == 0 && !m_eoc && v[0]) begin
            m_eoc  = 1'b1;
            m_exit = 32'(v >> 1) & 32'h7FFF_FFFF;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NW; i++) mem[i] = 64'd0;
        m_eoc  = 1'b0;
        m_exit = 32'd0;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("eoc_o", 64'(eoc_o), 64'(m_eoc));
            chk("exit_code_o", 64'(exit_code_o), 64'(m_exit));
            chk("irq_o", 64'(irq_o), 64'(mem[1][0]));
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_aw_ready"}, 64'(rsp.aw_ready), 64'd0);
        chk({tag, "_ar_ready"}, 64'(rsp.ar_ready), 64'd0);
        chk({tag, "_w_ready"}, 64'(rsp.w_ready), 64'd0);
        chk({tag, "_b_valid"}, 64'(rsp.b_valid), 64'd0);
        chk({tag, "_r_valid"}, 64'(rsp.r_valid), 64'd0);
        chk({tag, "_eoc"}, 64'(eoc_o), 64'd0);
        chk({tag, "_exit"}, 64'(exit_code_o), 64'd0);
        chk({tag, "_irq"}, 64'(irq_o), 64'd0);
    endtask

    task automatic issue_aw(input logic [7:0] id, input logic [63:0] a, input int len, input int bst);
        req.aw_id = id; req.aw_addr = a; req.aw_len = 8'(len);
        req.aw_size = 3'd3; req.aw_burst = 2'(bst); req.aw_valid = 1'b1;
    endtask

    task automatic issue_ar(input logic [7:0] id, input logic [63:0] a, input int len, input int bst);
        req.ar_id = id; req.ar_addr = a; req.ar_len = 8'(len);
        req.ar_size = 3'd3; req.ar_burst = 2'(bst); req.ar_valid = 1'b1;
    endtask

    task automatic wait_aw_grant(output bit ok);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp.aw_ready) break;
        end
        ok = rsp.aw_ready;
        g_other = rsp.ar_ready;
        chk("aw_ready", 64'(rsp.aw_ready), 64'd1);
        @(posedge clk); #1;
        req.aw_valid = 1'b0;
    endtask

    task automatic wait_ar_grant(output bit ok);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp.ar_ready) break;
        end
        ok = rsp.ar_ready;
        g_other = rsp.aw_ready;
        chk("ar_ready", 64'(rsp.ar_ready), 64'd1);
        @(posedge clk); #1;
        req.ar_valid = 1'b0;
    endtask

    task automatic write_data(input logic [7:0] id, input logic [63:0] a, input int len,
                              input int bst, input int wlast_at, input bit gaps);
        logic [63:0] cur;
        bit          err;
        cur = a;
        err = 1'b0;
        for (int k = 0; k <= wlast_at; k++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                req.w_valid = 1'b0;
                @(posedge clk); #1;
            end
            req.w_data = wd[k]; req.w_strb = ws[k];
            req.w_last = (k == wlast_at); req.w_valid = 1'b1;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (rsp.w_ready) break;
            end
            chk("w_ready", 64'(rsp.w_ready), 64'd1);
            if (!rsp.w_ready) begin
                req.w_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            if (m_oob(cur)) err = 1'b1;
            else m_write(cur, wd[k], ws[k]);
            if (bst != 0) cur = cur + 64'd8;
        end
        if (wlast_at != len) err = 1'b1;
        req.w_valid = 1'b0; req.w_last = 1'b0; req.b_ready = 1'b1;
        @(negedge clk);
        g_bresp = rsp.b_resp;
        chk("b_valid", 64'(rsp.b_valid), 64'd1);
        chk("b_resp", 64'(rsp.b_resp), err ? 64'd2 : 64'd0);
        chk("b_id", 64'(rsp.b_id), 64'(id));
        @(posedge clk); #1;
        req.b_ready = 1'b0;
    endtask

    task automatic read_data(input logic [7:0] id, input logic [63:0] a, input int len,
                             input int bst, input bit stall, input int stop_after);
        logic [63:0] cur;
        int          k;
        cur = a;
        k = 0;
        req.r_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int guard = 0; guard < 200 && k <= len; guard++) begin
            @(negedge clk);
            chk("r_valid", 64'(rsp.r_valid), 64'd1);
            if (!rsp.r_valid) break;
            chk("r_data", rsp.r_data, m_read(cur));
            chk("r_resp", 64'(rsp.r_resp), m_oob(cur) ? 64'd2 : 64'd0);
            chk("r_last", 64'(rsp.r_last), (k == len) ? 64'd1 : 64'd0);
            chk("r_id", 64'(rsp.r_id), 64'(id));
            if (req.r_ready) begin
                g_rdata[k] = rsp.r_data;
                g_rresp[k] = rsp.r_resp;
                k++;
                if (bst != 0) cur = cur + 64'd8;
            end
            @(posedge clk); #1;
            if (stop_after >= 0 && k == stop_after) break;
            req.r_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (stop_after < 0) chk("r_beats", 64'(k), 64'(len + 1));
        req.r_ready = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] id, input logic [63:0] a, input int len,
                            input int bst, input int wlast_at);
        bit ok;
        issue_aw(id, a, len, bst);
        wait_aw_grant(ok);
        if (ok) write_data(id, a, len, bst, wlast_at, 1'b0);
    endtask

    task automatic do_read(input logic [7:0] id, input logic [63:0] a, input int len, input int bst);
        bit ok;
        issue_ar(id, a, len, bst);
        wait_ar_grant(ok);
        if (ok) read_data(id, a, len, bst, 1'b0, -1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          ok;
        int          len;
        int          bst;
        int          wl;
        logic [63:0] a;
        logic [7:0]  id;

        req = '0;
        rst_i = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_reset("reset");
        @(posedge clk); #1;
        rst_i = 1'b0;
        cmp_en = 1'b1;

        // Simultaneous AW/AR twice after reset: write first, then read.
        wd[0] = 64'h1111_2222_3333_4444; ws[0] = 8'hFF;
        issue_aw(8'h03, BASE + 64'h18, 0, 1);
        issue_ar(8'h05, BASE + 64'h18, 0, 1);
        wait_aw_grant(ok);
        chk("tie1_ar_ready", 64'(g_other), 64'd0);
        write_data(8'h03, BASE + 64'h18, 0, 1, 0, 1'b0);
        wd[0] = 64'h5555_6666_7777_8888;
        issue_aw(8'h04, BASE + 64'h20, 0, 1);
        wait_ar_grant(ok);
        chk("tie2_aw_ready", 64'(g_other), 64'd0);
        read_data(8'h05, BASE + 64'h18, 0, 1, 1'b0, -1);
        chk("tie2_rdata_lit", g_rdata[0], 64'h1111_2222_3333_4444);
        wait_aw_grant(ok);
        write_data(8'h04, BASE + 64'h20, 0, 1, 0, 1'b0);

        // Single write and read-back.
        wd[0] = 64'hDEAD_BEEF_0000_0001; ws[0] = 8'hFF;
        do_write(8'h11, BASE + 64'h10, 0, 1, 0);
        chk("single_bresp_lit", 64'(g_bresp), 64'd0);
        do_read(8'h12, BASE + 64'h10, 0, 1);
        chk("single_rdata_lit", g_rdata[0], 64'hDEAD_BEEF_0000_0001);

        // INCR burst over words 4..7 with a partial strobe on beat 2.
        for (int k = 0; k < 4; k++) begin
            wd[k] = {32'hAAAA_0000 + 32'(k), 32'h5555_0000 + 32'(k)}; ws[k] = 8'hFF;
        end
        do_write(8'h20, BASE + 64'h20, 3, 1, 3);
        for (int k = 0; k < 4; k++) begin
            wd[k] = {32'hBBBB_0000 + 32'(k), 32'hCCCC_0000 + 32'(k)}; ws[k] = 8'hFF;
        end
        ws[2] = 8'h0F;
        do_write(8'h21, BASE + 64'h20, 3, 1, 3);
        do_read(8'h22, BASE + 64'h20, 3, 1);
        chk("incr_beat2_lit", g_rdata[2], 64'hAAAA_0002_CCCC_0002);
        chk("incr_beat3_lit", g_rdata[3], 64'hBBBB_0003_CCCC_0003);

        // End of computation: first trigger freezes the exit code.
        wd[0] = 64'h0000_0000_0000_002B; ws[0] = 8'hFF;
        do_write(8'h30, BASE, 0, 1, 0);
        chk("eoc_lit", 64'(eoc_o), 64'd1);
        chk("exit_lit", 64'(exit_code_o), 64'd21);
        wd[0] = 64'h1;
        do_write(8'h31, BASE, 0, 1, 0);
        chk("exit_frozen_lit", 64'(exit_code_o), 64'd21);
        do_read(8'h32, BASE, 0, 1);
        chk("tohost_rd_lit", g_rdata[0], 64'h1);

        // Interrupt loop-back.
        wd[0] = 64'hFFFF_0000_0000_0001; ws[0] = 8'hFF;
        do_write(8'h40, BASE + 64'h8, 0, 1, 0);
        chk("irq_set_lit", 64'(irq_o), 64'd1);
        do_read(8'h41, BASE + 64'h8, 0, 1);
        chk("irq_rd_lit", g_rdata[0], 64'h1);
        wd[0] = 64'h0;
        do_write(8'h42, BASE + 64'h8, 0, 1, 0);
        chk("irq_clr_lit", 64'(irq_o), 64'd0);

        // Error cases: overrun past the last word, below base, short w_last.
        wd[0] = 64'h7777_0000_0000_0007; wd[1] = 64'h8888_0000_0000_0008;
        ws[0] = 8'hFF; ws[1] = 8'hFF;
        do_write(8'h50, BASE + 64'h38, 1, 1, 1);
        chk("oob_bresp_lit", 64'(g_bresp), 64'd2);
        do_read(8'h51, BASE + 64'h38, 1, 1);
        chk("oob_rresp_lit", 64'(g_rresp[1]), 64'd2);
        chk("oob_rdata_lit", g_rdata[1], 64'd0);
        do_write(8'h52, BASE - 64'h8, 0, 1, 0);
        chk("below_bresp_lit", 64'(g_bresp), 64'd2);
        do_read(8'h53, BASE - 64'h8, 0, 1);
        do_write(8'h54, BASE + 64'h18, 3, 1, 1);
        chk("short_last_bresp_lit", 64'(g_bresp), 64'd2);
        do_read(8'h55, BASE + 64'h18, 1, 1);

        // FIXED and WRAP bursts.
        wd[0] = 64'h1; wd[1] = 64'h2; wd[2] = 64'h3;
        ws[0] = 8'hFF; ws[1] = 8'hFF; ws[2] = 8'hFF;
        do_write(8'h60, BASE + 64'h28, 2, 0, 2);
        do_read(8'h61, BASE + 64'h28, 2, 0);
        chk("fixed_lit", g_rdata[0], 64'h3);
        do_write(8'h62, BASE + 64'h18, 1, 2, 1);
        do_read(8'h63, BASE + 64'h18, 1, 2);

        // Randomised traffic with stalls, gaps and out-of-range addresses.
        for (int t = 0; t < 80; t++) begin
            a   = BASE - 64'd16 + 64'($urandom_range(0, 11)) * 64'd8;
            len = $urandom_range(0, 3);
            bst = $urandom_range(0, 2);
            id  = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k <= len; k++) begin
                    wd[k] = {$urandom, $urandom};
                    ws[k] = 8'($urandom);
                end
                wl = len;
                if (len > 0 && $urandom_range(0, 7) == 0) wl = $urandom_range(0, len - 1);
                issue_aw(id, a, len, bst);
                wait_aw_grant(ok);
                if (ok) write_data(id, a, len, bst, wl, 1'b1);
            end else begin
                issue_ar(id, a, len, bst);
                wait_ar_grant(ok);
                if (ok) read_data(id, a, len, bst, 1'b1, -1);
            end
        end

        // Reset in the middle of a long read burst.
        for (int k = 0; k < 8; k++) begin
            wd[k] = 64'hC0DE_0000_0000_0000 + 64'(k); ws[k] = 8'hFF;
        end
        do_write(8'h70, BASE + 64'h10, 5, 1, 5);
        issue_ar(8'h77, BASE, 7, 1);
        wait_ar_grant(ok);
        read_data(8'h77, BASE, 7, 1, 1'b0, 4);
        rst_i = 1'b1;
        req.r_ready = 1'b0;
        @(posedge clk); #1;
        model_reset();
        @(negedge clk);
        check_reset("midrst");
        @(posedge clk); #1;
        rst_i = 1'b0;
        do_read(8'h78, BASE + 64'h10, 0, 1);
        chk("post_rst_rdata_lit", g_rdata[0], 64'd0);
        do_write(8'h79, BASE + 64'h10, 0, 1, 0);
        do_read(8'h7A, BASE + 64'h10, 0, 1);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axi_eoc_mailbox.md
# axi_eoc_mailbox

AXI4 slave that consumes the 64-bit AXI master port exported by the `opentitan` top (`axi_req`/`axi_rsp`) and replaces the random AXI slave on that port in simulation and FPGA builds. It holds a small register file, and its word 0 is a RISC-V style `tohost` end-of-computation mailbox. A firmware write with bit 0 set latches a sticky done flag and a 31-bit exit code. A second register drives the Ibex external interrupt line, so firmware can loop back an interrupt without testbench timing hacks.

## Interface
Parameters:
- `axi_req_t`, default none: AXI4 request struct, same typedef as the top's `axi_req`.
- `axi_resp_t`, default none: AXI4 response struct.
- `AddrWidth`, default 64: AXI address width.
- `DataWidth`, default 64: AXI data width; only 64 is supported.
- `IdWidth`, default 8: AXI ID width.
- `NumWords`, default 8: number of 64-bit registers; power of two, ≥ 4.
- `BaseAddr`, default 64'h0: byte address of word 0; 8-byte aligned.

Ports:
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset; synchronous, active-high.
- `axi_req_i` in `axi_req_t`: AW/W/AR channels plus B/R ready.
- `axi_rsp_o` out `axi_resp_t`: AW/W/AR ready plus B/R channels.
- `eoc_o` out 1: sticky end-of-computation flag.
- `exit_code_o` out 32: `{1'b0, tohost[31:1]}` captured at EOC.
- `irq_o` out 1: level interrupt; equals `IRQ[0]`.

## Operation
- Register map (word index = (addr − BaseAddr) >> 3):
  - 0 `TOHOST`
  - 1 `IRQ` (bit 0 only; other bits read 0)
  - 2 `FROMHOST`
  - 3..NumWords−1 scratch
- Every register is read/write with per-byte `wstrb`.
- Only one transaction is active at a time. FSM states:
  - IDLE: if `aw_valid` or `ar_valid`, grant one. If both are valid, grant the channel not granted last (write wins the first tie after reset). Latch id, addr, len, burst.
  - WDATA: `w_ready`=1. Each handshake writes the current beat, then advances the address. Leave on the beat with `w_last`.
  - WRESP: `b_valid`=1 with latched id; `b_resp` = OKAY or SLVERR. Go to IDLE on `b_ready`.
  - RDATA: `r_valid`=1 with latched id. Assert `r_last` when the beat count equals len. Go to IDLE on `r_ready` & `r_last`.
- Bursts:
  - INCR and WRAP both advance the address by 8 per beat; WRAP is treated as INCR.
  - FIXED keeps the address.
  - Beat counter is 8 bits; len up to 255.
- Errors:
  - A beat whose word index is ≥ NumWords, or whose address is below BaseAddr, is not written and reads 0.
  - That beat sets a sticky SLVERR for the burst: the write response is SLVERR, and each such read beat returns SLVERR. All beats are still consumed.
  - A `w_last` that does not match len ends the burst at `w_last`; the response is SLVERR.
- EOC:
  - Trigger: first completed write beat to `TOHOST` with resulting data bit 0 = 1.
  - On trigger, set `eoc_o` and load `exit_code_o` = data[31:1].
  - Later `TOHOST` writes update the register only; `eoc_o`/`exit_code_o` stay frozen until reset.

## Timing
- Reset values: all registers 0; `eoc_o`=0, `exit_code_o`=0, `irq_o`=0; all `*_ready`/`*_valid`=0; FSM in IDLE.
- Reset asserted mid-burst: FSM returns to IDLE the next edge, and all valids drop. Partially written data stays only for beats already handshaken before the reset edge, then is cleared by reset.
- Ready signals:
  - `aw_ready`/`ar_ready` are high only in IDLE, combinationally from the grant, so accept is at cycle 0.
  - `w_ready` is high from cycle 1; W beats arriving before the AW grant are held off.
- Write: `b_valid` rises the cycle after the last W handshake.
- Read: first `r_valid` at cycle 1 after the AR handshake; one beat per cycle while `r_ready` is high. `r_data` is stable while stalled.
- EOC: `eoc_o` and `exit_code_o` update the cycle after the triggering W handshake, before B completes.
- `irq_o` follows `IRQ[0]` one cycle after the W handshake.

## Test plan
- Single write: 0xDEAD_BEEF_0000_0001 to BaseAddr+0x10 with strb 0xFF, then read it back → `b_resp` OKAY; the read returns the same value with `r_last`=1 at cycle 1 after AR.
- INCR burst: len=3 write to words 4..7 with strb 0x0F on beat 2 → a len=3 read returns 4 beats; beat 2 upper half is the old value.
- EOC: write 0x0000_0000_0000_002B to `TOHOST` → `eoc_o`=1 next cycle, `exit_code_o`=21. A later write of 0x1 leaves `exit_code_o`=21.
- IRQ: write 1 then 0 to `IRQ` → `irq_o` high exactly between the two write beats (+1 cycle). A read of `IRQ` returns 0x1 while set.
- Errors and arbitration:
  - Burst len=1 starting at word NumWords−1 → second beat dropped, `b_resp`=SLVERR.
  - AW and AR valid in the same cycle twice → write granted first, read second.
- Reset mid read burst (len=7, after beat 3) → `r_valid` low next cycle; all outputs at reset values; a new AR is then accepted normally.
